// File: rtl/gshare_spec_predictor_pkg.sv
// Shared types and default sizing for the gshare direction predictor.
// The typedefs cover only the default parameter set; parametrised logic sizes its own vectors.
package gshare_spec_predictor_pkg;

    localparam int DEF_IDX_BITS = 10;
    localparam int DEF_HIST_LEN = 8;
    localparam int DEF_CTR_BITS = 2;

    typedef logic [DEF_CTR_BITS-1:0] bp_ctr_t;
    typedef logic [DEF_HIST_LEN-1:0] gshare_hist_t;

    localparam bp_ctr_t BP_CTR_WEAK_NT = bp_ctr_t'((1 << (DEF_CTR_BITS - 1)) - 1);

endpackage

// File: rtl/gshare_spec_predictor_if.sv
// Predict (fetch) and resolve (BRU/ROB) signal bundle for the gshare predictor.
// master = fetch/resolution side, slave = predictor.
interface gshare_spec_predictor_if #(
    parameter int HIST_LEN = 8
);
    logic                predict_valid;
    logic [31:0]         predict_pc;
    logic                prediction;
    logic [HIST_LEN-1:0] predict_hist;

    logic                update_valid;
    logic [31:0]         update_pc;
    logic                update_taken;
    logic [HIST_LEN-1:0] update_hist;
    logic                update_mispredict;
    logic                flush;

    modport master (
        output predict_valid, predict_pc,
        output update_valid, update_pc, update_taken, update_hist, update_mispredict, flush,
        input  prediction, predict_hist
    );

    modport slave (
        input  predict_valid, predict_pc,
        input  update_valid, update_pc, update_taken, update_hist, update_mispredict, flush,
        output prediction, predict_hist
    );
endinterface

// File: rtl/gshare_spec_predictor_pht.sv
// Pattern history table: saturating counters, one async read port, one sync write port.
// Every entry is returned to weakly not-taken in the single reset cycle, which also cancels a write.
module bp_sat_counter_table #(
    parameter int IDX_BITS = 10,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);
    localparam int                  ENTRIES = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] wr_old;
    logic [CTR_BITS-1:0] wr_ctr_d;

    assign rd_ctr = ctr_q[rd_idx];
    assign wr_old = ctr_q[wr_idx];

    always_comb begin
        wr_ctr_d = wr_old;
        if (wr_taken && (wr_old != CTR_MAX)) begin
            wr_ctr_d = wr_old + 1'b1;
        end else if (!wr_taken && (wr_old != CTR_MIN)) begin
            wr_ctr_d = wr_old - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare direction predictor with speculative (predict-time) and architectural (resolve-time) history.
// Each prediction exports its history so the resolving branch trains exactly the entry it read.
module gshare_spec_predictor
    import gshare_spec_predictor_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int CTR_BITS = DEF_CTR_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    gshare_spec_predictor_if.slave  bp
);
    logic [HIST_LEN-1:0] spec_hist_q, spec_hist_d;
    logic [HIST_LEN-1:0] arch_hist_q, arch_hist_d;
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0] pred_ctr;
    logic                unused_bits;

    // Index = word-aligned PC slice XOR zero-extended history.
    assign pred_idx = bp.predict_pc[IDX_BITS+1:2] ^ IDX_BITS'(spec_hist_q);
    assign upd_idx  = bp.update_pc[IDX_BITS+1:2]  ^ IDX_BITS'(bp.update_hist);

    assign bp.prediction   = pred_ctr[CTR_BITS-1];
    assign bp.predict_hist = spec_hist_q;

    assign unused_bits = ^{bp.predict_pc[31:IDX_BITS+2], bp.predict_pc[1:0],
                           bp.update_pc[31:IDX_BITS+2], bp.update_pc[1:0]};

    bp_sat_counter_table #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .srst     (rst),
        .rd_idx   (pred_idx),
        .rd_ctr   (pred_ctr),
        .wr_en    (bp.update_valid),
        .wr_idx   (upd_idx),
        .wr_taken (bp.update_taken)
    );

    always_comb begin
        arch_hist_d = arch_hist_q;
        if (bp.update_valid) begin
            arch_hist_d = {arch_hist_q[HIST_LEN-2:0], bp.update_taken};
        end
    end

    // Flush restores committed history (including this cycle's resolution);
    // a mispredict rebuilds from the branch's own snapshot and drops any same-cycle predict shift.
    always_comb begin
        spec_hist_d = spec_hist_q;
        if (bp.flush) begin
            spec_hist_d = arch_hist_d;
        end else if (bp.update_valid && bp.update_mispredict) begin
            spec_hist_d = {bp.update_hist[HIST_LEN-2:0], bp.update_taken};
        end else if (bp.predict_valid) begin
            spec_hist_d = {spec_hist_q[HIST_LEN-2:0], bp.prediction};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_hist_q <= '0;
            arch_hist_q <= '0;
        end else begin
            spec_hist_q <= spec_hist_d;
            arch_hist_q <= arch_hist_d;
        end
    end

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor at default parameters (IDX 10, HIST 8, CTR 2).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_gshare_spec_predictor;
    import gshare_spec_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    gshare_spec_predictor_if #(.HIST_LEN(8)) bp_if ();

    gshare_spec_predictor #(
        .IDX_BITS (10),
        .HIST_LEN (8),
        .CTR_BITS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        if (obs === exp) $display("[TB] check %s value=0x%0h", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp_if.predict_valid     = 1'b0;
        bp_if.update_valid      = 1'b0;
        bp_if.update_mispredict = 1'b0;
        bp_if.update_taken      = 1'b0;
        bp_if.update_hist       = 8'h00;
        bp_if.flush             = 1'b0;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic taken,
                              input logic [7:0] hist, input logic mis);
        bp_if.update_valid      = 1'b1;
        bp_if.update_pc         = pc;
        bp_if.update_taken      = taken;
        bp_if.update_hist       = hist;
        bp_if.update_mispredict = mis;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bp_if.predict_pc = 32'h0;
        bp_if.update_pc  = 32'h0;

        // Reset state
        do_reset();
        bp_if.predict_pc = 32'h100;
        #1;
        chk("reset_pred", 32'(bp_if.prediction), 32'h0);
        chk("reset_hist", 32'(bp_if.predict_hist), 32'h00);
        chk("reset_pht40", 32'(dut.u_pht.ctr_q[10'h040]), 32'(BP_CTR_WEAK_NT));

        // Three taken updates saturate PHT[0x40]: 01 -> 10 -> 11 -> 11
        set_update(32'h100, 1'b1, 8'h00, 1'b0);
        tick();
        chk("sat_ctr1", 32'(dut.u_pht.ctr_q[10'h040]), 32'h2);
        tick();
        chk("sat_ctr2", 32'(dut.u_pht.ctr_q[10'h040]), 32'h3);
        tick();
        chk("sat_ctr3", 32'(dut.u_pht.ctr_q[10'h040]), 32'h3);
        idle_inputs();
        #1;
        chk("sat_spec_unchanged", 32'(bp_if.predict_hist), 32'h00);
        chk("sat_pred_taken", 32'(bp_if.prediction), 32'h1);
        // Flush with no update exposes arch_hist (three taken -> 0x07)
        bp_if.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("flush_arch_07", 32'(bp_if.predict_hist), 32'h07);
        chk("pred_hist07_idx47", 32'(bp_if.prediction), 32'h0);

        // Four not-taken predicts at 0x200 keep spec_hist at zero
        do_reset();
        bp_if.predict_pc    = 32'h200;
        bp_if.predict_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("nt_seq_hist%0d", i), 32'(bp_if.predict_hist), 32'h00);
            chk($sformatf("nt_seq_pred%0d", i), 32'(bp_if.prediction), 32'h0);
            tick();
        end
        idle_inputs();
        // Mispredict repair from snapshot 0x05, taken -> 0x0B; trains idx 0xC0^0x05
        set_update(32'h300, 1'b1, 8'h05, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("mis_repair_0B", 32'(bp_if.predict_hist), 32'h0B);
        chk("mis_train_C5", 32'(dut.u_pht.ctr_q[10'h0C5]), 32'h2);
        chk("mis_untouched_C0", 32'(dut.u_pht.ctr_q[10'h0C0]), 32'h1);

        // Same-cycle predict and mispredict: recovery 0x60 wins over predict shift 0x16
        bp_if.predict_valid = 1'b1;
        bp_if.predict_pc    = 32'h100;
        set_update(32'h400, 1'b0, 8'h30, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("mis_vs_pred_60", 32'(bp_if.predict_hist), 32'h60);
        chk("dec_ctr_130", 32'(dut.u_pht.ctr_q[10'h130]), 32'h0);
        set_update(32'h400, 1'b0, 8'h30, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("dec_floor_130", 32'(dut.u_pht.ctr_q[10'h130]), 32'h0);
        chk("no_mis_spec_hold", 32'(bp_if.predict_hist), 32'h60);

        // Build arch_hist = 0x03, then flush together with a taken update -> 0x07
        do_reset();
        set_update(32'h500, 1'b1, 8'h00, 1'b0);
        tick();
        tick();
        set_update(32'h500, 1'b1, 8'h00, 1'b0);
        bp_if.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("flush_upd_spec_07", 32'(bp_if.predict_hist), 32'h07);
        bp_if.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("flush_arch_07b", 32'(bp_if.predict_hist), 32'h07);
        // Flush beats mispredict: arch 0x07 -> 0x0E, not recovery 0xE0
        set_update(32'h600, 1'b0, 8'hF0, 1'b1);
        bp_if.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("flush_over_mis_0E", 32'(bp_if.predict_hist), 32'h0E);
        // Taken predictions shift 1 into spec_hist (PHT[0x140] = 11)
        bp_if.predict_valid = 1'b1;
        bp_if.predict_pc    = 32'h538;
        #1;
        chk("pred_taken_538", 32'(bp_if.prediction), 32'h1);
        tick();
        chk("pred_shift_1D", 32'(bp_if.predict_hist), 32'h1D);
        bp_if.predict_pc = 32'h574;
        #1;
        chk("pred_taken_574", 32'(bp_if.prediction), 32'h1);
        tick();
        idle_inputs();
        #1;
        chk("pred_shift_3B", 32'(bp_if.predict_hist), 32'h3B);

        // Same-entry update and predict: old value this cycle, new value next cycle
        do_reset();
        bp_if.predict_pc = 32'h600;
        set_update(32'h600, 1'b1, 8'h00, 1'b0);
        #1;
        chk("no_bypass_pred", 32'(bp_if.prediction), 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("after_write_pred", 32'(bp_if.prediction), 32'h1);
        // Reset cancels a simultaneous update
        set_update(32'h700, 1'b1, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        bp_if.predict_pc = 32'h700;
        #1;
        chk("rst_cancel_1C0", 32'(dut.u_pht.ctr_q[10'h1C0]), 32'h1);
        chk("rst_clear_180", 32'(dut.u_pht.ctr_q[10'h180]), 32'h1);
        chk("rst_cancel_pred", 32'(bp_if.prediction), 32'h0);
        chk("rst_cancel_hist", 32'(bp_if.predict_hist), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
